rv_alu_structural: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_shifter.sv | 28 ++
 rtl/rv_alu_structural.sv | 81 ++++++++
 tb/tb_rv_alu_structural.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I execute-stage ALU.
// Operation codes follow the funct7[5]/funct3 packing used by the decoder.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_t;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Five-stage logarithmic barrel shifter shared by SLL, SRL and SRA.
// Only a right shifter is built; left shifts mirror the data on the way in and out.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    output logic [XLEN-1:0]    result
);

    logic [XLEN-1:0] stage [0:SHAMT_W];
    logic            fill;

    // arith is only set for SRA, so a mirrored left shift always fills with zero
    assign fill     = arith & data[XLEN-1];
    assign stage[0] = dir ? bit_reverse(data) : data;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        assign stage[i+1] = shamt[i]
            ? {{(1 << i){fill}}, stage[i][XLEN-1:(1 << i)]}
            : stage[i];
    end

    assign result = dir ? bit_reverse(stage[SHAMT_W]) : stage[SHAMT_W];

endmodule

// File: rtl/rv_alu_structural.sv
// RV32I execute-stage ALU: shared adder/subtractor, comparators, logic unit,
// barrel shifter, result mux and the EX/MEM result register.
module rv_alu_structural
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] result_q,
    output logic            zero
);

    alu_op_t         op;
    logic            sub_op;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;
    logic            carry_out;
    logic            overflow;
    logic            slt_bit;
    logic            sltu_bit;
    logic            shift_left;
    logic            shift_arith;
    logic [XLEN-1:0] shift_out;
    logic [XLEN-1:0] result_d;

    assign op = alu_op_t'(alu_control);

    // Comparisons reuse the subtractor rather than building separate comparators
    always_comb begin
        sub_op    = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
        b_eff     = b ^ {XLEN{sub_op}};
        sum       = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub_op};
        carry_out = sum[XLEN];
        overflow  = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
        slt_bit   = sum[XLEN-1] ^ overflow;
        sltu_bit  = ~carry_out;
    end

    assign shift_left  = (op == ALU_SLL);
    assign shift_arith = (op == ALU_SRA);

    alu_shifter u_shifter (
        .data   (a),
        .shamt  (b[SHAMT_W-1:0]),
        .dir    (shift_left),
        .arith  (shift_arith),
        .result (shift_out)
    );

    always_comb begin
        result_d = '0;
        case (op)
            ALU_ADD,
            ALU_SUB:  result_d = sum[XLEN-1:0];
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result_d = shift_out;
            ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, slt_bit};
            ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, sltu_bit};
            ALU_XOR:  result_d = a ^ b;
            ALU_OR:   result_d = a | b;
            ALU_AND:  result_d = a & b;
            default:  result_d = '0;
        endcase
    end

    assign result = result_d;
    assign zero   = (result_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_rv_alu_structural.sv
// Self-checking bench for rv_alu_structural: directed vector table, randomized
// operations against an arithmetic reference model, and clock/reset sequences.
module tb_rv_alu_structural;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [31:0] result_q;
    logic        zero;

    int total;
    int bad;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    rv_alu_structural dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .result      (result),
        .result_q    (result_q),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model straight from the instruction semantics
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [31:0] r;
        int          sh;
        sh = int'(y % 32);
        case (op)
            4'b0000: r = x + y;
            4'b0001: r = x << sh;
            4'b0010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0011: r = (x < y) ? 32'd1 : 32'd0;
            4'b0100: r = x ^ y;
            4'b0101: r = x >> sh;
            4'b0110: r = x | y;
            4'b0111: r = x & y;
            4'b1000: r = x - y;
            4'b1101: r = $signed(x) >>> sh;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        alu_control = op;
        a           = x;
        b           = y;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] r, input logic z);
        vec_t v;
        v.name = name; v.op = op; v.a = x; v.b = y; v.exp_result = r; v.exp_zero = z;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] exp_r;

        total = 0;
        bad   = 0;

        add_vec("add_basic",   4'b0000, 32'h0000_0010, 32'h0000_0005, 32'h0000_0015, 1'b0);
        add_vec("add_wrap",    4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        add_vec("sub_basic",   4'b1000, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0);
        add_vec("sub_wrap",    4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        add_vec("sll_4",       4'b0001, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0);
        add_vec("srl_31",      4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0);
        add_vec("sra_4",       4'b1101, 32'hF000_0000, 32'h0000_0004, 32'hFF00_0000, 1'b0);
        add_vec("sra_pos",     4'b1101, 32'h7000_0000, 32'h0000_0004, 32'h0700_0000, 1'b0);
        add_vec("sll_hi_b",    4'b0001, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0);
        add_vec("srl_hi_b",    4'b0101, 32'h8000_0000, 32'hFFFF_FFE1, 32'h4000_0000, 1'b0);
        add_vec("slt_neg",     4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
        add_vec("sltu_neg",    4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        add_vec("slt_ovf",     4'b0010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        add_vec("slt_ovf_rev", 4'b0010, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1);
        add_vec("sltu_lt",     4'b0011, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0);
        add_vec("xor",         4'b0100, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0);
        add_vec("or",          4'b0110, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0);
        add_vec("and",         4'b0111, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1);
        add_vec("illegal_a",   4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        add_vec("illegal_f",   4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1);
        add_vec("illegal_9",   4'b1001, 32'h0000_0010, 32'h0000_0001, 32'h0000_0000, 1'b1);

        // Reset held from time zero: register must be cleared without any edge
        rst_n = 1'b0;
        applyStimulus(4'b0000, 32'h0000_0003, 32'h0000_0004);
        #1;
        checkOutput("reset_result_q", result_q, 32'h0);
        checkOutput("reset_comb_tracks", result, 32'h0000_0007);

        // Release reset away from an edge, then one edge captures 3 + 4
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_capture", result_q, 32'h0000_0007);
        applyStimulus(4'b0000, 32'h0000_000A, 32'h0000_000A);
        #1;
        checkOutput("hold_after_change", result_q, 32'h0000_0007);
        checkOutput("new_comb", result, 32'h0000_0014);
        @(negedge clk);
        checkOutput("hold_to_negedge", result_q, 32'h0000_0007);
        @(posedge clk);
        #1;
        checkOutput("second_capture", result_q, 32'h0000_0014);

        // Assert reset mid-cycle: immediate clear, combinational path unaffected
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", result_q, 32'h0);
        checkOutput("comb_in_reset", result, 32'h0000_0014);
        @(posedge clk);
        #1;
        checkOutput("reset_held_edge", result_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            checkOutput({vecs[i].name, "_result"}, result, vecs[i].exp_result);
            checkOutput({vecs[i].name, "_zero"}, {31'b0, zero}, {31'b0, vecs[i].exp_zero});
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_q"}, result_q, vecs[i].exp_result);
        end

        for (int n = 0; n < 300; n++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = 32'($urandom_range(0, 63));
                default: rb = $urandom;
            endcase
            exp_r = ref_alu(rop, ra, rb);
            @(negedge clk);
            applyStimulus(rop, ra, rb);
            #1;
            checkOutput("rand_result", result, exp_r);
            checkOutput("rand_zero", {31'b0, zero}, {31'b0, (exp_r == 32'h0)});
            @(posedge clk);
            #1;
            checkOutput("rand_q", result_q, exp_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
